// File: rtl/bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = A - B), one bit per clock, LSB first.
// Shares the load/start/done handshake of the bit-serial adder.
module bit_serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_hold, b_hold;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CW-1:0]    cnt_q;
  logic             bin_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic a_bit, b_bit, d_bit, bout, last_bit;

  assign a_bit    = a_sr[0];
  assign b_bit    = b_sr[0];
  assign d_bit    = a_bit ^ b_bit ^ bin_q;
  assign bout     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = LOADED;
      LOADED:  if (load) state_d = LOADED;
               else if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    if (load) state_d = LOADED;
               else if (start) state_d = SHIFT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold   <= '0;
      b_hold   <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= {d_bit, r_sr[WIDTH-1:1]};
          bin_q <= bout;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            diff_q   <= {d_bit, r_sr[WIDTH-1:1]};
            borrow_q <= bout;
          end
        end
        default: begin
          if (load) begin
            a_hold <= A;
            b_hold <= B;
            a_sr   <= A;
            b_sr   <= B;
          end else if (start && state_q != IDLE) begin
            // Reload from the holding copies so a re-run from DONE sees the original operands.
            a_sr  <= a_hold;
            b_sr  <= b_hold;
            r_sr  <= '0;
            cnt_q <= '0;
            bin_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor: expected results are queued at
// start and compared when done rises.
module tb_bit_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] diff;
  logic         borrow, busy, done;

  typedef struct packed {
    logic [W-1:0] d;
    logic         b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .start(start),
    .A(A), .B(B), .diff(diff), .borrow(borrow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic pulse_load(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    A = a; B = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Leaves the bench at the negedge of the first SHIFT cycle.
  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.d = a - b;
    e.b = (a < b);
    sb.push_back(e);
  endtask

  task automatic wait_done(output logic [W-1:0] d, output logic b,
                           output int bc, output bit to);
    bc = 0;
    for (int i = 0; i < 40 && done !== 1'b1; i++) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
    end
    to = (done !== 1'b1);
    d  = diff;
    b  = borrow;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({diff, borrow, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got diff=%h borrow=%b busy=%b done=%b want all 0",
               diff, borrow, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_start_ignored got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] d; logic b; int bc; bit to; exp_t e;
    pulse_load(4'd9, 4'd3);
    pulse_start(4'd9, 4'd3);
    wait_done(d, b, bc, to);
    e = sb.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout done=%b want 1", done); end
    checks++;
    if ({d, b} !== {e.d, e.b}) begin
      errors++;
      $display("FAIL basic_result got diff=%h borrow=%b want diff=%h borrow=%b", d, b, e.d, e.b);
    end
    checks++;
    if (bc !== W) begin errors++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, W); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || diff !== 4'd6) begin
      errors++;
      $display("FAIL basic_done_level got done=%b diff=%h want 1 6", done, diff);
    end
  endtask

  task automatic test_borrow;
    logic [W-1:0] ta[3] = '{4'd3, 4'd15, 4'd0};
    logic [W-1:0] tb[3] = '{4'd9, 4'd15, 4'd1};
    logic [W-1:0] wd[3] = '{4'hA, 4'h0, 4'hF};
    logic         wb[3] = '{1'b1, 1'b0, 1'b1};
    logic [W-1:0] d; logic b; int bc; bit to; exp_t e;
    for (int i = 0; i < 3; i++) begin
      pulse_load(ta[i], tb[i]);
      pulse_start(ta[i], tb[i]);
      wait_done(d, b, bc, to);
      e = sb.pop_front();
      checks++;
      if (to || {d, b} !== {wd[i], wb[i]} || {e.d, e.b} !== {wd[i], wb[i]}) begin
        errors++;
        $display("FAIL borrow_case%0d got diff=%h borrow=%b timeout=%b want diff=%h borrow=%b",
                 i, d, b, to, wd[i], wb[i]);
      end
    end
  endtask

  task automatic test_midshift_inputs;
    logic [W-1:0] d; logic b; int bc; bit to; exp_t e;
    pulse_load(4'd9, 4'd3);
    pulse_start(4'd9, 4'd3);
    @(negedge clk);
    A = 4'd5; B = 4'd5; load = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b1;
    A = W'($urandom); B = W'($urandom);
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    wait_done(d, b, bc, to);
    e = sb.pop_front();
    checks++;
    if (to || {d, b} !== {e.d, e.b}) begin
      errors++;
      $display("FAIL midshift_ignore got diff=%h borrow=%b timeout=%b want diff=%h borrow=%b",
               d, b, to, e.d, e.b);
    end
  endtask

  task automatic test_reset_midshift;
    bit active;
    pulse_load(4'd9, 4'd3);
    pulse_start(4'd9, 4'd3);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({diff, borrow, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_midshift got diff=%h borrow=%b busy=%b done=%b want all 0",
               diff, borrow, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    active = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0) active = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (active) begin
      errors++;
      $display("FAIL start_after_reset got activity=1 want 0");
    end
  endtask

  task automatic test_load_start;
    logic [W-1:0] d; logic b; int bc; bit to; exp_t e;
    pulse_load(4'd1, 4'd1);
    @(negedge clk);
    A = 4'd7; B = 4'd2; load = 1'b1; start = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_start_stays_loaded got busy=%b done=%b want 0 0", busy, done);
    end
    pulse_start(4'd7, 4'd2);
    wait_done(d, b, bc, to);
    e = sb.pop_front();
    checks++;
    if (to || {d, b} !== {e.d, e.b} || d !== 4'd5) begin
      errors++;
      $display("FAIL load_start_result got diff=%h borrow=%b want diff=5 borrow=0", d, b);
    end
    A = 4'd0; B = 4'd0;
    pulse_start(4'd7, 4'd2);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rerun_enters_shift got done=%b busy=%b want 0 1", done, busy);
    end
    wait_done(d, b, bc, to);
    e = sb.pop_front();
    checks++;
    if (to || {d, b} !== {e.d, e.b} || bc !== W) begin
      errors++;
      $display("FAIL rerun_result got diff=%h borrow=%b busy_cycles=%0d want diff=%h borrow=%b busy_cycles=%0d",
               d, b, bc, e.d, e.b, W);
    end
    pulse_load(4'd3, 4'd3);
    checks++;
    if (done !== 1'b0 || diff !== 4'd5) begin
      errors++;
      $display("FAIL diff_holds_in_loaded got done=%b diff=%h want 0 5", done, diff);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, bb, d, sum; logic b; int bc; bit to; exp_t e;
    for (int i = 0; i < 200; i++) begin
      a  = W'($urandom);
      bb = W'($urandom);
      pulse_load(a, bb);
      pulse_start(a, bb);
      wait_done(d, b, bc, to);
      e = sb.pop_front();
      checks++;
      if (to || {d, b} !== {e.d, e.b}) begin
        errors++;
        $display("FAIL random_%0d A=%h B=%h got diff=%h borrow=%b want diff=%h borrow=%b",
                 i, a, bb, d, b, e.d, e.b);
      end
      sum = d + bb;
      checks++;
      if (sum !== a) begin
        errors++;
        $display("FAIL random_add_back_%0d got diff+B=%h want A=%h", i, sum, a);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_borrow;
    test_midshift_inputs;
    test_reset_midshift;
    test_load_start;
    test_random;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serial_subtractor.md
Name: bit_serial_subtractor

Overview:
- Bit-serial two's-complement subtractor, DIFF = A - B, with borrow-out. Processes one bit per clock, LSB first.
- Inverse arithmetic counterpart of the team's bit-serial adder. Uses the same load/start/done handshake so both blocks plug into the same top/TB harness.
- Sits beside the adder in the datapath exercises. A shared TB drives both blocks with identical operand sequences.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  capture A/B into internal shift registers
- start  input  1  begin serial subtraction of loaded operands
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- diff  output  WIDTH  registered result A - B mod 2^WIDTH
- borrow  output  1  final borrow-out (1 when A < B unsigned)
- busy  output  1  high while shifting
- done  output  1  result valid; level, not pulse

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
- Reset (async, any state): state=IDLE, shift regs=0, bit counter=0, borrow flop=0.
  - Outputs on reset: diff=0, borrow=0, busy=0, done=0.
- FSM states: IDLE, LOADED, SHIFT, DONE.
- IDLE:
  - load=1 -> capture A,B; go to LOADED.
  - start alone is ignored; no operands are present.
- LOADED:
  - start=1 -> SHIFT; counter=0; internal borrow-in=0.
  - load=1 -> re-capture A,B; stay LOADED.
  - load and start together -> load wins; re-capture and stay LOADED.
- SHIFT: each edge processes the LSBs a, b of the shift regs and shifts them right by one.
  - d = a^b^bin
  - bout = (~a&b) | (~(a^b)&bin)
  - d enters the MSB of the result shift reg; bin <= bout; counter++.
  - load and start are ignored throughout SHIFT.
  - busy=1 throughout SHIFT.
- SHIFT exit: after the WIDTH-th SHIFT edge -> DONE.
  - On that edge: diff <= complete result; borrow <= final bout.
- Latency: start sampled at edge t0 -> done=1 and diff/borrow valid after edge t0+WIDTH.
- diff/borrow are registered outputs. They hold the previous result during LOADED/SHIFT and update only on entry to DONE.
- DONE:
  - done=1 holds until exit.
  - load=1 -> capture new operands; go to LOADED; done falls.
  - start alone -> re-run on the same operands: SHIFT with operands restored from the retained copies.
    - Requires separate operand holding registers alongside the shift regs.
  - load and start together -> load wins.
- Width rules:
  - Result wraps mod 2^WIDTH.
  - borrow=1 iff A<B unsigned.
  - diff must equal (A + ~B + 1) truncated.
- Reset mid-SHIFT: immediate abort to IDLE; all outputs 0; a partial result is never presented.
- A/B are only sampled on accepted load edges. Changes at other times must not affect the result.

Test Plan:
1. WIDTH=4: load A=9,B=3; start -> after 4 SHIFT edges diff=6, borrow=0, done=1; busy high exactly 4 cycles.
2. Borrow and full-range cases:
   - A=3,B=9 -> diff=0xA, borrow=1.
   - A=15,B=15 -> diff=0, borrow=0.
   - A=0,B=1 -> diff=0xF, borrow=1.
3. Load/A/B during SHIFT:
   - Assert load with A=5,B=5 on the 2nd SHIFT cycle of 9-3 -> ignored; result 6.
   - Toggle A/B freely mid-shift -> no effect.
4. Reset mid-operation: assert rst_n=0 on the 3rd SHIFT cycle -> immediately diff=0, borrow=0, busy=0, done=0, state IDLE.
   - A following start without load -> no activity.
5. Simultaneous load+start:
   - In LOADED with A=7,B=2 -> stays LOADED with new operands, no busy.
   - Next start -> diff=5.
   - From DONE: start alone re-runs -> same diff again after 4 cycles.
6. Randomized cross-check, 200 iterations: random A,B -> diff==(A-B)&0xF and borrow==(A<B).
   - Run alongside the adder; check adder(diff,B)==A.
